// File: rtl/button_press_classifier.sv
// button_press_classifier: classifies debounced button edges into short, long and double presses
module button_press_classifier #(
    parameter int TICK_DIV     = 100_000,
    parameter int LONG_TICKS   = 1000,
    parameter int DOUBLE_TICKS = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rise_i,
    input  logic       fall_i,
    input  logic       evt_ack_i,
    output logic       short_press_o,
    output logic       long_press_o,
    output logic       double_press_o,
    output logic       held_o,
    output logic       evt_valid_o,
    output logic [1:0] evt_code_o,
    output logic       evt_overflow_o
);
    localparam int MAXT = LONG_TICKS > DOUBLE_TICKS ? LONG_TICKS : DOUBLE_TICKS;
    localparam int CW   = $clog2(MAXT + 1);
    localparam int PW   = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, PRESSED, HELD_LONG, WAIT2, PRESSED2} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    code_d, code_q;
    logic          short_q, long_q, double_q, held_q, valid_q, ovf_q;
    logic          tick, rise, fall, long_to, dbl_to;

    assign tick    = presc_q == PW'(TICK_DIV - 1);
    assign rise    = rise_i & ~fall_i;
    assign fall    = fall_i & ~rise_i;
    assign long_to = tick && cnt_q == CW'(LONG_TICKS - 1);
    assign dbl_to  = tick && cnt_q == CW'(DOUBLE_TICKS - 1);

    // next state and event code; an edge always beats a timeout in the same cycle
    always_comb begin
        state_d = state_q;
        code_d  = 2'b00;
        case (state_q)
            IDLE:      state_d = rise ? PRESSED : IDLE;
            PRESSED: begin
                if (fall) begin
                    state_d = WAIT2;
                end else if (long_to) begin
                    state_d = HELD_LONG;
                    code_d  = 2'b10;
                end
            end
            HELD_LONG: state_d = fall ? IDLE : HELD_LONG;
            WAIT2: begin
                if (rise) begin
                    state_d = PRESSED2;
                end else if (dbl_to) begin
                    state_d = IDLE;
                    code_d  = 2'b01;
                end
            end
            PRESSED2: begin
                if (fall) begin
                    state_d = IDLE;
                    code_d  = 2'b11;
                end else if (long_to) begin
                    state_d = HELD_LONG;
                    code_d  = 2'b11;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    // timing, state, registered pulses and the software event latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            held_q   <= 1'b0;
            valid_q  <= 1'b0;
            code_q   <= 2'b00;
            ovf_q    <= 1'b0;
        end else begin
            presc_q  <= tick ? '0 : presc_q + 1'b1;
            state_q  <= state_d;
            cnt_q    <= state_d != state_q ? '0 : (tick && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
            held_q   <= state_d inside {PRESSED, PRESSED2, HELD_LONG};
            short_q  <= code_d == 2'b01;
            long_q   <= code_d == 2'b10;
            double_q <= code_d == 2'b11;
            if (code_d != 2'b00) begin
                code_q  <= code_d;
                valid_q <= 1'b1;
                ovf_q   <= ~evt_ack_i & (ovf_q | valid_q);
            end else if (evt_ack_i && valid_q) begin
                code_q  <= 2'b00;
                valid_q <= 1'b0;
                ovf_q   <= 1'b0;
            end
        end
    end

    assign short_press_o  = short_q;
    assign long_press_o   = long_q;
    assign double_press_o = double_q;
    assign held_o         = held_q;
    assign evt_valid_o    = valid_q;
    assign evt_code_o     = code_q;
    assign evt_overflow_o = ovf_q;
endmodule
